// File: rtl/splitter.sv
// Registers a 32-bit word as four bytes one cycle after capture (SWAP picks byte order); no backpressure.
// Define SPLITTER_PARITY_EN to add a registered per-byte even-parity output P.
module splitter #(
  parameter bit SWAP = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic        in_valid,
  output logic [7:0]  O1,
  output logic [7:0]  O2,
  output logic [7:0]  O3,
  output logic [7:0]  O4,
`ifdef SPLITTER_PARITY_EN
  output logic [3:0]  P,
`endif
  output logic        out_valid
);

  logic [7:0] b1, b2, b3, b4;

  always_comb begin
    b1 = A[31:24];
    b2 = A[23:16];
    b3 = A[15:8];
    b4 = A[7:0];
    if (SWAP) begin
      b1 = A[7:0];
      b2 = A[15:8];
      b3 = A[23:16];
      b4 = A[31:24];
    end
  end

  // Bytes hold on idle edges; only out_valid drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      O1        <= 8'h00;
      O2        <= 8'h00;
      O3        <= 8'h00;
      O4        <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        O1 <= b1;
        O2 <= b2;
        O3 <= b3;
        O4 <= b4;
      end
    end
  end

`ifdef SPLITTER_PARITY_EN
  // Parity is computed from the incoming bytes so it lands on the same edge as O1..O4.
  always_ff @(posedge clk) begin
    if (reset) begin
      P <= 4'b0000;
    end else if (in_valid) begin
      P <= {^b1, ^b2, ^b3, ^b4};
    end
  end
`endif

endmodule

// File: tb/tb_splitter.sv
// Scoreboard bench: directed vectors driven into SWAP=0 and SWAP=1 instances, checked per cycle by a monitor.
module tb_splitter;

  bit          clk;
  logic        reset;
  logic [31:0] A;
  logic        in_valid;
  logic [7:0]  o1_0, o2_0, o3_0, o4_0, o1_1, o2_1, o3_1, o4_1;
  logic        ov_0, ov_1;
`ifdef SPLITTER_PARITY_EN
  logic [3:0]  p_0, p_1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  splitter #(.SWAP(1'b0)) u0 (
    .clk(clk), .reset(reset), .A(A), .in_valid(in_valid),
    .O1(o1_0), .O2(o2_0), .O3(o3_0), .O4(o4_0),
`ifdef SPLITTER_PARITY_EN
    .P(p_0),
`endif
    .out_valid(ov_0)
  );

  splitter #(.SWAP(1'b1)) u1 (
    .clk(clk), .reset(reset), .A(A), .in_valid(in_valid),
    .O1(o1_1), .O2(o2_1), .O3(o3_1), .O4(o4_1),
`ifdef SPLITTER_PARITY_EN
    .P(p_1),
`endif
    .out_valid(ov_1)
  );

  // rst, vld, a: stimulus; v, e0/e1, p0/p1: hand-computed response one cycle later.
  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] a;
    logic        v;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [3:0]  p0;
    logic [3:0]  p1;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];
  vec_t expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("valid_swap0", {31'd0, ov_0}, {31'd0, e.v});
        chk("valid_swap1", {31'd0, ov_1}, {31'd0, e.v});
        chk("bytes_swap0", {o1_0, o2_0, o3_0, o4_0}, e.e0);
        chk("bytes_swap1", {o1_1, o2_1, o3_1, o4_1}, e.e1);
`ifdef SPLITTER_PARITY_EN
        chk("parity_swap0", {28'd0, p_0}, {28'd0, e.p0});
        chk("parity_swap1", {28'd0, p_1}, {28'd0, e.p1});
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    // Reset held two cycles against an all-ones word with in_valid high.
    vecs[0]  = '{1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000000, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000000, 4'b0000, 4'b0000};
    vecs[2]  = '{1'b0, 1'b1, 32'h12345678, 1'b1, 32'h12345678, 32'h78563412, 4'b0100, 4'b0010};
    vecs[3]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h12345678, 32'h78563412, 4'b0100, 4'b0010};
    // Back-to-back captures.
    vecs[4]  = '{1'b0, 1'b1, 32'hAABBCCDD, 1'b1, 32'hAABBCCDD, 32'hDDCCBBAA, 4'b0000, 4'b0000};
    vecs[5]  = '{1'b0, 1'b1, 32'h01020304, 1'b1, 32'h01020304, 32'h04030201, 4'b1101, 4'b1011};
    vecs[6]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 32'h01020304, 32'h04030201, 4'b1101, 4'b1011};
    vecs[7]  = '{1'b0, 1'b1, 32'h01030700, 1'b1, 32'h01030700, 32'h00070301, 4'b1010, 4'b0101};
    // Reset mid-stream discards the word presented with it.
    vecs[8]  = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 32'hEFBEADDE, 4'b0101, 4'b1010};
    vecs[9]  = '{1'b1, 1'b1, 32'h11111111, 1'b0, 32'h00000000, 32'h00000000, 4'b0000, 4'b0000};
    vecs[10] = '{1'b0, 1'b0, 32'h22222222, 1'b0, 32'h00000000, 32'h00000000, 4'b0000, 4'b0000};
    vecs[11] = '{1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 32'h0DF0FECA, 4'b0101, 4'b1010};
    vecs[12] = '{1'b0, 1'b1, 32'h80000001, 1'b1, 32'h80000001, 32'h01000080, 4'b1001, 4'b1001};
    vecs[13] = '{1'b0, 1'b0, 32'h5A5A5A5A, 1'b0, 32'h80000001, 32'h01000080, 4'b1001, 4'b1001};

    for (int i = 0; i < NV; i++) begin
      reset    = vecs[i].rst;
      in_valid = vecs[i].vld;
      A        = vecs[i].a;
      expq.push_back(vecs[i]);
      @(posedge clk);
      #1;
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    A        = 32'h0;

    for (int k = 0; k < 5 && expq.size() != 0; k++) @(negedge clk);
    @(posedge clk);
    n_checks++;
    if (expq.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", expq.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
